// File: rtl/chip_invaders_pkg.sv
// rtl/chip_invaders_pkg.sv - shared types and helpers for the chip invaders game logic
package chip_invaders_pkg;

    localparam int SCORE_W = 16;
    localparam int COORD_W = 16;

    typedef enum logic [2:0] {
        HIT_WAIT    = 3'd0,
        HIT_ARMED   = 3'd1,
        HIT_COL_DIV = 3'd2,
        HIT_ROW_DIV = 3'd3,
        HIT_COMMIT  = 3'd4
    } hit_state_e;

    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/cell_index_divider.sv
// rtl/cell_index_divider.sv - iterative subtract divider mapping a pixel offset to a cell index
module cell_index_divider
    import chip_invaders_pkg::*;
#(
    parameter int DIVISOR = 64,
    parameter int LIMIT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               start,
    input  logic [COORD_W:0]   dividend,
    output logic               done,
    output logic               overflow,
    output logic [COORD_W-1:0] quotient
);

    localparam logic [COORD_W:0]   DIV_V  = (COORD_W+1)'(DIVISOR);
    localparam logic [COORD_W-1:0] LAST_Q = COORD_W'(LIMIT - 1);

    logic               busy;
    logic [COORD_W:0]   rem;
    logic [COORD_W-1:0] q;
    logic               rem_ge;
    logic               at_limit;

    // One more subtraction from the last legal index would step outside the grid.
    assign rem_ge   = (rem >= DIV_V);
    assign at_limit = (q == LAST_Q);
    assign done     = busy & (~rem_ge | at_limit);
    assign overflow = busy & rem_ge & at_limit;
    assign quotient = q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            rem  <= '0;
            q    <= '0;
        end else if (clear) begin
            busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            rem  <= dividend;
            q    <= '0;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                rem <= rem - DIV_V;
                q   <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alien_hit_detector.sv
// rtl/alien_hit_detector.sv - resolves bullet/alien coincidences to cell kills and owns the alive matrix
module alien_hit_detector
    import chip_invaders_pkg::*;
#(
    parameter int NUM_ROWS         = 2,
    parameter int NUM_COLUMNS      = 4,
    parameter int ALIEN_SPACING_X  = 64,
    parameter int ALIEN_SPACING_Y  = 32,
    parameter int POINTS_PER_ALIEN = 10
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [COORD_W-1:0]                    scan_x,
    input  logic [COORD_W-1:0]                    scan_y,
    input  logic                                  frame_start,
    input  logic                                  alien_pixel,
    input  logic                                  bullet_pixel,
    input  logic [COORD_W-1:0]                    formation_x,
    input  logic [COORD_W-1:0]                    formation_y,
    input  logic                                  formation_reset,
    output logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alive_matrix,
    output logic                                  kill_valid,
    output logic [COORD_W-1:0]                    kill_row,
    output logic [COORD_W-1:0]                    kill_col,
    output logic                                  bullet_hit,
    output logic [SCORE_W-1:0]                    score,
    output logic                                  all_dead
);

    localparam logic [SCORE_W-1:0] POINTS = SCORE_W'(POINTS_PER_ALIEN);

    hit_state_e state, next_state;

    logic                                 coincide;
    logic [COORD_W:0]                     dx, dy, dy_q;
    logic                                 hit_neg;
    logic                                 col_start, row_start, commit_en;
    logic                                 col_done, col_ovf, row_done, row_ovf;
    logic [COORD_W-1:0]                   col_q, row_q;
    logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] target;
    logic                                 target_alive;

    assign coincide = alien_pixel & bullet_pixel;
    assign dx       = {1'b0, scan_x} - {1'b0, formation_x};
    assign dy       = {1'b0, scan_y} - {1'b0, formation_y};
    assign hit_neg  = dx[COORD_W] | dy[COORD_W];
    assign all_dead = ~|alive_matrix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HIT_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (formation_reset) begin
            next_state = HIT_WAIT;
        end else begin
            case (state)
                HIT_WAIT:    if (frame_start) next_state = HIT_ARMED;
                HIT_ARMED:   if (coincide) next_state = hit_neg ? HIT_WAIT : HIT_COL_DIV;
                HIT_COL_DIV: if (col_done) next_state = col_ovf ? HIT_WAIT : HIT_ROW_DIV;
                HIT_ROW_DIV: if (row_done) next_state = row_ovf ? HIT_WAIT : HIT_COMMIT;
                HIT_COMMIT:  next_state = HIT_WAIT;
                default:     next_state = HIT_WAIT;
            endcase
        end
    end

    always_comb begin
        col_start = (state == HIT_ARMED) && coincide && !hit_neg && !formation_reset;
        row_start = (state == HIT_COL_DIV) && col_done && !col_ovf && !formation_reset;
        commit_en = (state == HIT_COMMIT) && !formation_reset;
    end

    // The column divider consumes dx directly; dy waits here for the row pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dy_q <= '0;
        end else if (col_start) begin
            dy_q <= dy;
        end
    end

    cell_index_divider #(
        .DIVISOR (ALIEN_SPACING_X),
        .LIMIT   (NUM_COLUMNS)
    ) u_col_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (formation_reset),
        .start    (col_start),
        .dividend (dx),
        .done     (col_done),
        .overflow (col_ovf),
        .quotient (col_q)
    );

    cell_index_divider #(
        .DIVISOR (ALIEN_SPACING_Y),
        .LIMIT   (NUM_ROWS)
    ) u_row_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (formation_reset),
        .start    (row_start),
        .dividend (dy_q),
        .done     (row_done),
        .overflow (row_ovf),
        .quotient (row_q)
    );

    always_comb begin
        target = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                if (row_q == COORD_W'(r) && col_q == COORD_W'(c)) begin
                    target[r][c] = 1'b1;
                end
            end
        end
    end

    assign target_alive = |(alive_matrix & target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_matrix <= '1;
            score        <= '0;
            kill_valid   <= 1'b0;
            bullet_hit   <= 1'b0;
            kill_row     <= '0;
            kill_col     <= '0;
        end else begin
            kill_valid <= 1'b0;
            bullet_hit <= 1'b0;
            if (formation_reset) begin
                alive_matrix <= '1;
            end else if (commit_en && target_alive) begin
                alive_matrix <= alive_matrix & ~target;
                kill_valid   <= 1'b1;
                bullet_hit   <= 1'b1;
                kill_row     <= row_q;
                kill_col     <= col_q;
                score        <= sat_add(score, POINTS);
            end
        end
    end

endmodule

// File: tb/tb_alien_hit_detector.sv
// tb/tb_alien_hit_detector.sv - scoreboard bench for alien_hit_detector
module tb_alien_hit_detector;

    typedef struct {
        int         row;
        int         col;
        int         score;
        logic [7:0] alive;
        int         issue;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      scan_x, scan_y, formation_x, formation_y;
    logic             frame_start, alien_pixel, bullet_pixel, formation_reset;
    logic [1:0][3:0]  alive_matrix;
    logic             kill_valid, bullet_hit, all_dead;
    logic [15:0]      kill_row, kill_col, score;

    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;
    bit        sb_en   = 1'b1;
    exp_t      exp_q[$];
    logic [1:0][3:0] m_alive;
    int        m_score;
    bit        m_armed;

    alien_hit_detector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .scan_x          (scan_x),
        .scan_y          (scan_y),
        .frame_start     (frame_start),
        .alien_pixel     (alien_pixel),
        .bullet_pixel    (bullet_pixel),
        .formation_x     (formation_x),
        .formation_y     (formation_y),
        .formation_reset (formation_reset),
        .alive_matrix    (alive_matrix),
        .kill_valid      (kill_valid),
        .kill_row        (kill_row),
        .kill_col        (kill_col),
        .bullet_hit      (bullet_hit),
        .score           (score),
        .all_dead        (all_dead)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: cell = floor(offset / pitch), one hit per armed frame.
    task automatic model_hit(input int sx, input int sy, input int issue);
        int col, row;
        exp_t e;
        if (!m_armed) return;
        m_armed = 1'b0;
        if (sx < int'(formation_x) || sy < int'(formation_y)) return;
        col = (sx - int'(formation_x)) / 64;
        row = (sy - int'(formation_y)) / 32;
        if (col >= 4 || row >= 2) return;
        if (!m_alive[row][col]) return;
        m_alive[row][col] = 1'b0;
        m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
        e.row = row; e.col = col; e.score = m_score; e.alive = m_alive; e.issue = issue;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            if (kill_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_kill", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("kill_row", kill_row, e.row);
                    check("kill_col", kill_col, e.col);
                    check("kill_score", score, e.score);
                    check("kill_alive", alive_matrix, e.alive);
                    check("kill_bullet_hit", bullet_hit, 1);
                    check("kill_latency_le9", (cyc - e.issue) <= 9, 1);
                end
            end else if (bullet_hit) begin
                check("stray_bullet_hit", bullet_hit, 0);
            end
        end
    end

    task automatic frame();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        m_armed = 1'b1;
    endtask

    task automatic frst();
        @(posedge clk); #1 formation_reset = 1'b1;
        @(posedge clk); #1 formation_reset = 1'b0;
        m_alive = '1;
        m_armed = 1'b0;
    endtask

    task automatic hit(input int sx, input int sy);
        @(posedge clk); #1;
        scan_x = 16'(sx); scan_y = 16'(sy);
        alien_pixel = 1'b1; bullet_pixel = 1'b1;
        @(posedge clk); #1;
        model_hit(sx, sy, cyc);
        alien_pixel = 1'b0; bullet_pixel = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, any_supp, any_kill;
        rst_n = 1'b0; scan_x = '0; scan_y = '0; frame_start = 1'b0;
        alien_pixel = 1'b0; bullet_pixel = 1'b0; formation_reset = 1'b0;
        formation_x = 16'd50; formation_y = 16'd50;
        m_alive = '1; m_score = 0; m_armed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_alive", alive_matrix, 8'hFF);
        check("rst_score", score, 0);
        check("rst_kill_valid", kill_valid, 0);
        check("rst_bullet_hit", bullet_hit, 0);
        check("rst_kill_row", kill_row, 0);
        check("rst_kill_col", kill_col, 0);
        check("rst_all_dead", all_dead, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed: first kill, same-frame repeat, next frame
        frame();
        hit(180, 90);
        check("t1_score", score, 10);
        hit(60, 60);
        frame();
        hit(60, 60);
        check("t2_score", score, 20);

        // Discards, then a coincidence with no new frame
        frame();
        hit(20, 90);
        frame();
        hit(310, 60);
        hit(120, 60);
        check("t3_alive", alive_matrix, m_alive);

        // Already-dead cell
        frame();
        hit(180, 90);
        check("t4_score", score, 20);

        // Randomized frames, origins and scan points
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) frst();
            formation_x = 16'($urandom_range(0, 150));
            formation_y = 16'($urandom_range(0, 120));
            if ($urandom_range(0, 3) != 0) frame();
            hit($urandom_range(0, 450), $urandom_range(0, 250));
            if ($urandom_range(0, 3) == 0) hit($urandom_range(0, 450), $urandom_range(0, 250));
            check("rand_alive", alive_matrix, m_alive);
            check("rand_score", score, m_score);
        end

        // formation_reset swept across the resolution of cell (1,3)
        formation_x = 16'd50; formation_y = 16'd50;
        sb_en = 1'b0;
        any_supp = 0; any_kill = 0;
        for (int k = 1; k <= 10; k++) begin
            frst();
            frame();
            @(posedge clk); #1;
            scan_x = 16'd247; scan_y = 16'd87;
            alien_pixel = 1'b1; bullet_pixel = 1'b1;
            @(posedge clk); #1;
            alien_pixel = 1'b0; bullet_pixel = 1'b0;
            seen = 0;
            for (int t = 1; t <= 12; t++) begin
                formation_reset = (t == k);
                @(posedge clk);
                @(negedge clk);
                if (kill_valid && seen == 0) seen = t;
            end
            formation_reset = 1'b0;
            m_alive = '1; m_armed = 1'b0;
            if (seen != 0) begin
                any_kill = 1;
                check("frst_kill_before_reset", seen < k, 1);
                m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
            end else begin
                any_supp = 1;
            end
            check("frst_alive", alive_matrix, 8'hFF);
            check("frst_score", score, m_score);
        end
        check("frst_some_suppressed", any_supp, 1);
        check("frst_some_committed", any_kill, 1);
        sb_en = 1'b1;

        // Async reset mid-division
        frame();
        @(posedge clk); #1;
        scan_x = 16'd247; scan_y = 16'd87;
        alien_pixel = 1'b1; bullet_pixel = 1'b1;
        @(posedge clk); #1;
        alien_pixel = 1'b0; bullet_pixel = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_alive", alive_matrix, 8'hFF);
        check("arst_score", score, 0);
        check("arst_kill_valid", kill_valid, 0);
        check("arst_bullet_hit", bullet_hit, 0);
        check("arst_kill_row", kill_row, 0);
        check("arst_kill_col", kill_col, 0);
        m_alive = '1; m_score = 0; m_armed = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        hit(247, 87);

        // Clear the whole formation
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                frame();
                hit(50 + c * 64 + 10, 50 + r * 32 + 10);
            end
        end
        check("final_all_dead", all_dead, 1);
        check("final_score", score, 80);
        check("final_alive", alive_matrix, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
